// File: rtl/rgb565_gray4_sequencer.sv
// rgb565_gray4_sequencer
//   Multi-cycle custom-instruction unit: converts four packed RGB565 pixels
//   ({ciValueB, ciValueA}, pixel k in bits [16k+15:16k]) to four 8-bit gray
//   bytes using one shared datapath, one pixel per enabled cycle.
// Ports
//   clock     in   system clock
//   reset     in   synchronous active-high reset (overrides ciCke)
//   ciStart   in   start strobe
//   ciCke     in   clock enable; all state frozen while low
//   ciN       in   [7:0]  custom-instruction id
//   ciValueA  in   [31:0] pixel0 = [15:0], pixel1 = [31:16]
//   ciValueB  in   [31:0] pixel2 = [15:0], pixel3 = [31:16]
//   ciDone    out  result valid for one enabled cycle
//   ciResult  out  [31:0] gray byte k in [8k+7:8k]; 0 while ciDone = 0
module rgb565_gray4_sequencer #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_count;
  logic [63:0] r_pixels;
  logic [31:0] r_bytes;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_hit;
  logic [15:0] w_pixel;
  logic [7:0]  w_r8;
  logic [7:0]  w_g8;
  logic [7:0]  w_b8;
  logic [16:0] w_sum;
  logic [7:0]  w_gray;

  assign w_hit = ciStart && (ciN == customInstructionId);

  always_comb begin
    w_pixel = r_pixels[15:0];
    case (r_count)
      2'd0:    w_pixel = r_pixels[15:0];
      2'd1:    w_pixel = r_pixels[31:16];
      2'd2:    w_pixel = r_pixels[47:32];
      default: w_pixel = r_pixels[63:48];
    endcase
  end

  // Shared grayscale datapath; the weights sum to 256, so the peak of
  // 64220 fits in 16 bits and gray never exceeds 250.
  assign w_r8   = {w_pixel[15:11], 3'b000};
  assign w_g8   = {w_pixel[10:5], 2'b00};
  assign w_b8   = {w_pixel[4:0], 3'b000};
  assign w_sum  = 17'd54  * {9'd0, w_r8}
                + 17'd183 * {9'd0, w_g8}
                + 17'd19  * {9'd0, w_b8};
  assign w_gray = 8'(w_sum >> 8);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_pixels <= '0;
      r_bytes  <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (ciCke) begin
      case (r_state)
        IDLE: begin
          r_done   <= 1'b0;
          r_result <= '0;
          if (w_hit) begin
            r_pixels <= {ciValueB, ciValueA};
            r_count  <= '0;
            r_state  <= CONVERT;
          end
        end
        CONVERT: begin
          case (r_count)
            2'd0:    r_bytes[7:0]   <= w_gray;
            2'd1:    r_bytes[15:8]  <= w_gray;
            2'd2:    r_bytes[23:16] <= w_gray;
            default: r_bytes[31:24] <= w_gray;
          endcase
          r_count <= r_count + 2'd1;
          if (r_count == 2'd3) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // Result is published on the edge leaving DONE; the following
          // enabled IDLE edge clears it, giving a one-cycle ciDone pulse.
          r_done   <= 1'b1;
          r_result <= r_bytes;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ciDone   = r_done;
  assign ciResult = r_result;

endmodule

// File: tb/tb_rgb565_gray4_sequencer.sv
// tb_rgb565_gray4_sequencer
//   Self-checking bench: a vector table of {A, B, expected result} plus
//   hand-written sequences for clock-enable stalls, reset abort, id mismatch
//   and starts ignored while busy. Expected results go into a scoreboard
//   queue at start and are compared when ciDone rises.
module tb_rgb565_gray4_sequencer;

  localparam logic [7:0] ID = 8'd0;

  logic        clock;
  logic        reset;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;

  rgb565_gray4_sequencer #(.customInstructionId(ID)) dut (
    .clock    (clock),
    .reset    (reset),
    .ciStart  (ciStart),
    .ciCke    (ciCke),
    .ciN      (ciN),
    .ciValueA (ciValueA),
    .ciValueB (ciValueB),
    .ciDone   (ciDone),
    .ciResult (ciResult)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;
  logic [31:0] sb[$];
  logic prev_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: result compared on each rising ciDone; outside
  // ciDone the result bus must read zero.
  always @(negedge clock) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (ciDone && !prev_done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done with result %h expected no done (cycle %0d)",
                   ciResult, cyc);
        end else begin
          logic [31:0] exp;
          exp = sb.pop_front();
          if (ciResult !== exp) begin
            errors++;
            $display("FAIL sb_result: got %h expected %h (cycle %0d)", ciResult, exp, cyc);
          end
        end
      end else if (!ciDone) begin
        checks++;
        if (ciResult !== 32'h0) begin
          errors++;
          $display("FAIL idle_result_zero: got %h expected 00000000 (cycle %0d)", ciResult, cyc);
        end
      end
      prev_done = ciDone;
    end
  end

  // Drive a start for one cycle; returns at the negedge after the sampling
  // edge with t_start set to that edge's index.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] n,
                          input bit push, input logic [31:0] exp);
    @(negedge clock);
    ciStart  = 1'b1;
    ciN      = n;
    ciValueA = a;
    ciValueB = b;
    if (push) sb.push_back(exp);
    @(negedge clock);
    t_start = cyc;
    ciStart = 1'b0;
    ciN     = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 0; n < 30; n++) begin
      if (ciDone) begin
        lat = cyc - t_start;
        break;
      end
      @(negedge clock);
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 30 cycles (cycle %0d)", cyc);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat;

    tbl[0] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFAFA_FAFA};
    tbl[1] = '{a: 32'h07E0_F800, b: 32'h0000_001F, exp: 32'h0012_B434};
    tbl[2] = '{a: 32'h0000_0000, b: 32'h0000_0000, exp: 32'h0000_0000};
    tbl[3] = '{a: 32'h0821_8410, b: 32'hFFFF_0001, exp: 32'hFA00_0580};
    tbl[4] = '{a: 32'hF800_07E0, b: 32'h001F_8410, exp: 32'h1280_34B4};

    // Reset with random inputs; reset must win over ciCke.
    reset    = 1'b1;
    ciStart  = $urandom;
    ciCke    = $urandom;
    ciN      = ID;
    ciValueA = $urandom;
    ciValueB = $urandom;
    @(negedge clock);
    chk("reset_done", {31'd0, ciDone}, 32'd0);
    chk("reset_result", ciResult, 32'd0);
    ciStart = $urandom;
    @(negedge clock);
    chk("reset_done2", {31'd0, ciDone}, 32'd0);
    chk("reset_result2", ciResult, 32'd0);
    reset   = 1'b0;
    ciStart = 1'b0;
    ciCke   = 1'b1;
    @(negedge clock);

    // Table-driven operations, each with latency check.
    for (int i = 0; i < 5; i++) begin
      start_op(tbl[i].a, tbl[i].b, ID, 1'b1, tbl[i].exp);
      wait_done(lat);
      chk($sformatf("tbl%0d_latency", i), lat, 32'd5);
      chk($sformatf("tbl%0d_result", i), ciResult, tbl[i].exp);
      @(negedge clock);
      chk($sformatf("tbl%0d_done_pulse", i), {31'd0, ciDone}, 32'd0);
      chk($sformatf("tbl%0d_result_clear", i), ciResult, 32'd0);
    end

    // Wrong id: ignored.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h5A, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk("badid_done", {31'd0, ciDone}, 32'd0);
      chk("badid_result", ciResult, 32'd0);
      @(negedge clock);
    end

    // Clock-enable stalls: 3 frozen cycles in CONVERT, 2 in DONE.
    start_op(32'h07E0_F800, 32'h0000_001F, ID, 1'b1, 32'h0012_B434);
    @(negedge clock);
    ciCke = 1'b0;
    repeat (3) @(negedge clock);
    ciCke = 1'b1;
    wait_done(lat);
    chk("cke_latency", lat, 32'd8);
    chk("cke_result", ciResult, 32'h0012_B434);
    ciCke = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("cke_done_hold", {31'd0, ciDone}, 32'd1);
      chk("cke_result_hold", ciResult, 32'h0012_B434);
    end
    ciCke = 1'b1;
    @(negedge clock);
    chk("cke_done_release", {31'd0, ciDone}, 32'd0);

    // Reset at start + 2 aborts; then a fresh operation completes.
    start_op(32'h07E0_F800, 32'h0000_001F, ID, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done", {31'd0, ciDone}, 32'd0);
      @(negedge clock);
    end
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, ID, 1'b1, 32'hFAFA_FAFA);
    wait_done(lat);
    chk("after_abort_latency", lat, 32'd5);
    chk("after_abort_result", ciResult, 32'hFAFA_FAFA);
    @(negedge clock);

    // Second start during CONVERT is ignored; original operands survive.
    start_op(32'h07E0_F800, 32'h0000_001F, ID, 1'b1, 32'h0012_B434);
    @(negedge clock);
    ciStart  = 1'b1;
    ciN      = ID;
    ciValueA = 32'hFFFF_FFFF;
    ciValueB = 32'hFFFF_FFFF;
    @(negedge clock);
    ciStart = 1'b0;
    wait_done(lat);
    chk("busy_start_latency", lat, 32'd5);
    chk("busy_start_result", ciResult, 32'h0012_B434);
    repeat (8) @(negedge clock);

    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
